// File: rtl/router_pkg.sv
// Shared definitions for the router input-side arbiter and its round-robin picker.
package router_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_XFER  = 2'b01,
        S_DRAIN = 2'b10
    } arb_state_t;

    localparam int MAX_PORTS = 4;
    localparam int IDX_W     = 2;

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first requester after rr_ptr, modulo N_PORTS.
// Also intended for the output-side read arbiter.
module router_rr_pick
    import router_pkg::*;
#(
    parameter int N_PORTS = 3
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [N_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0]   pos;
    logic [N_PORTS-1:0] mask;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        mask   = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            pos  = IDX_W'((int'(rr_ptr) + k) % N_PORTS);
            mask = N_PORTS'(1) << pos;
            if (!any && ((req & mask) != '0)) begin
                any    = 1'b1;
                onehot = mask;
                idx    = pos;
            end
        end
    end

endmodule

// File: rtl/router_in_arbiter.sv
// Round-robin arbiter sharing the router datapath between N_PORTS packet sources.
// Optional drain watchdog: ROUTER_ARB_WATCHDOG_EN.
//
// state   | meaning
// S_IDLE  | no grant; arbitrate when a request is pending and the router is not busy
// S_XFER  | grant held while the source streams header and payload
// S_DRAIN | parity byte point passed; grant held until the router drops busy
module router_in_arbiter
    import router_pkg::*;
#(
    parameter int N_PORTS       = 3,
    parameter int DW            = 8,
    parameter int DRAIN_TIMEOUT = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_PORTS-1:0]    req,
    input  logic [N_PORTS*DW-1:0] src_data,
    input  logic                  busy,
    input  logic                  stall,
    input  logic                  abort,
    output logic [N_PORTS-1:0]    grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid,
    output logic                  pkt_valid_out,
    output logic [DW-1:0]         data_out,
    output logic                  timeout_err
);

    if (N_PORTS < 2 || N_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("router_in_arbiter: N_PORTS out of range");
    end
    if (DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 31) begin : g_bad_timeout
        $error("router_in_arbiter: DRAIN_TIMEOUT must fit the 5-bit watchdog");
    end

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [N_PORTS-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 req_granted;

    router_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // grant is all-zero when nothing is held, so this is req[grant_idx] gated by grant_valid
    assign req_granted   = |(req & grant);
    assign pkt_valid_out = grant_valid & req_granted;

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) data_out = src_data[i*DW +: DW];
        end
    end

`ifdef ROUTER_ARB_WATCHDOG_EN
    logic [4:0] wd_cnt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= IDX_W'(N_PORTS - 1);
`ifdef ROUTER_ARB_WATCHDOG_EN
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef ROUTER_ARB_WATCHDOG_EN
            timeout_err <= 1'b0;
`endif
            if (abort) begin
                state       <= S_IDLE;
                grant       <= '0;
                grant_idx   <= '0;
                grant_valid <= 1'b0;
                if (grant_valid) rr_ptr <= grant_idx;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pick_any && !busy) begin
                            grant       <= pick_onehot;
                            grant_idx   <= pick_idx;
                            grant_valid <= 1'b1;
                            state       <= S_XFER;
                        end
                    end
                    S_XFER: begin
                        if (!req_granted && !stall) begin
                            state  <= S_DRAIN;
`ifdef ROUTER_ARB_WATCHDOG_EN
                            wd_cnt <= 5'(DRAIN_TIMEOUT - 1);
`endif
                        end
                    end
                    S_DRAIN: begin
                        if (!busy) begin
                            state       <= S_IDLE;
                            grant       <= '0;
                            grant_idx   <= '0;
                            grant_valid <= 1'b0;
                            rr_ptr      <= grant_idx;
`ifdef ROUTER_ARB_WATCHDOG_EN
                        end else if (wd_cnt == 5'd0) begin
                            // router never released busy: free the datapath anyway
                            state       <= S_IDLE;
                            grant       <= '0;
                            grant_idx   <= '0;
                            grant_valid <= 1'b0;
                            rr_ptr      <= grant_idx;
                            timeout_err <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt - 5'd1;
`endif
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef ROUTER_ARB_WATCHDOG_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_in_arbiter.sv
// Directed bench for router_in_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_router_in_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] src_data;
    logic        busy;
    logic        stall;
    logic        abort;
    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic        grant_valid;
    logic        pkt_valid_out;
    logic [7:0]  data_out;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    router_in_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .src_data      (src_data),
        .busy          (busy),
        .stall         (stall),
        .abort         (abort),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .pkt_valid_out (pkt_valid_out),
        .data_out      (data_out),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] src;
        logic        busy;
        logic        stall;
        logic        abort;
        logic [2:0]  e_grant;
        logic [1:0]  e_idx;
        logic        e_valid;
        logic        e_pv;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] eg, input logic [1:0] ei,
                              input logic ev, input logic epv, input logic [7:0] ed,
                              input logic eto);
        chk({tag, ".grant"},       32'(grant),         32'(eg));
        chk({tag, ".grant_idx"},   32'(grant_idx),     32'(ei));
        chk({tag, ".grant_valid"}, 32'(grant_valid),   32'(ev));
        chk({tag, ".pkt_valid"},   32'(pkt_valid_out), 32'(epv));
        chk({tag, ".data_out"},    32'(data_out),      32'(ed));
        chk({tag, ".timeout_err"}, 32'(timeout_err),   32'(eto));
    endtask

    // Expected outputs when port p is (or is not) granted, derived from the driven inputs.
    task automatic check_grant(input string tag, input logic valid, input int p);
        logic [2:0] eg;
        logic [1:0] ei;
        logic       epv;
        logic [7:0] ed;
        eg  = valid ? 3'(1 << p) : 3'b000;
        ei  = valid ? 2'(p) : 2'd0;
        epv = valid && ((req & eg) != 3'b000);
        ed  = valid ? 8'(src_data >> (8 * p)) : 8'h00;
        check_outs(tag, eg, ei, valid, epv, ed, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        req      = 3'b000;
        busy     = 1'b0;
        stall    = 1'b0;
        abort    = 1'b0;
        src_data = 24'hC2B1A0;
        #1;
        check_outs("reset", 3'b000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // One complete packet on lone requester p, starting and ending in S_IDLE.
    task automatic do_packet(input int p);
        req  = 3'(1 << p);
        busy = 1'b0;
        #1 check_grant("pkt.idle", 1'b0, 0);
        tick();
        check_grant("pkt.xfer", 1'b1, p);
        busy = 1'b1;
        tick();
        req = 3'b000;
        tick();
        busy = 1'b0;
        #1 check_grant("pkt.drain", 1'b1, p);
        tick();
        check_grant("pkt.done", 1'b0, 0);
    endtask

    initial begin
        vecs[0] = '{3'b010, 24'hC211A0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{3'b010, 24'hC212A0, 1'b1, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b1, 8'h12};
        vecs[2] = '{3'b010, 24'hC313A1, 1'b1, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b1, 8'h13};
        vecs[3] = '{3'b000, 24'hC35AA1, 1'b1, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 8'h5A};
        vecs[4] = '{3'b000, 24'hC35AA1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 8'h5A};
        vecs[5] = '{3'b000, 24'hC35AA1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{3'b010, 24'hC421A4, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{3'b010, 24'hC422A4, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b1, 8'h22};

        reset = 1'b1; req = '0; src_data = '0; busy = 1'b0; stall = 1'b0; abort = 1'b0;
        tick();
        do_reset();

        // single source, back-to-back re-grant of a lone requester
        for (int i = 0; i < 8; i++) begin
            req      = vecs[i].req;
            src_data = vecs[i].src;
            busy     = vecs[i].busy;
            stall    = vecs[i].stall;
            abort    = vecs[i].abort;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_idx,
                       vecs[i].e_valid, vecs[i].e_pv, vecs[i].e_data, 1'b0);
            tick();
        end

        // contention: reset mid-packet, then 0,1,2,0 with an idle cycle between grants
        do_reset();
        begin
            int order [4] = '{0, 1, 2, 0};
            for (int n = 0; n < 4; n++) begin
                req  = 3'b111;
                busy = 1'b0;
                #1 check_grant($sformatf("rr%0d.idle", n), 1'b0, 0);
                tick();
                check_grant($sformatf("rr%0d.grant", n), 1'b1, order[n]);
                busy = 1'b1;
                tick();
                req = 3'b111 & ~3'(1 << order[n]);
                #1 check_grant($sformatf("rr%0d.parity", n), 1'b1, order[n]);
                tick();
                busy = 1'b0;
                tick();
            end
        end

        // stall at end of packet holds S_XFER
        do_reset();
        req = 3'b001;
        tick();
        check_grant("stall.grant", 1'b1, 0);
        busy = 1'b1;
        tick();
        req = 3'b000; stall = 1'b1; busy = 1'b0;
        tick();
        check_grant("stall.hold1", 1'b1, 0);
        tick();
        check_grant("stall.hold2", 1'b1, 0);
        stall = 1'b0;
        tick();
        check_grant("stall.drain", 1'b1, 0);
        tick();
        check_grant("stall.release", 1'b0, 0);

        // busy blocks arbitration in S_IDLE
        do_reset();
        req = 3'b001; busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_grant($sformatf("busy.block%0d", c), 1'b0, 0);
        end
        busy = 1'b0;
        #1 check_grant("busy.free", 1'b0, 0);
        tick();
        check_grant("busy.grant", 1'b1, 0);

        // abort on port 2: grant cleared, port 0 wins next
        do_reset();
        do_packet(1);
        req = 3'b101;
        tick();
        check_grant("abort.grant2", 1'b1, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_grant("abort.cleared", 1'b0, 0);
        tick();
        check_grant("abort.next", 1'b1, 0);

        // busy stuck high in S_DRAIN
        do_reset();
        req = 3'b001;
        tick();
        busy = 1'b1;
        req  = 3'b000;
        tick();
`ifdef ROUTER_ARB_WATCHDOG_EN
        for (int c = 0; c < 30; c++) tick();
        check_grant("wd.held", 1'b1, 0);
        tick();
        check_outs("wd.fire", 3'b000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check_outs("wd.pulse", 3'b000, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
`else
        for (int c = 0; c < 40; c++) tick();
        check_grant("wd.held", 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/router_in_arbiter.md
Name: router_in_arbiter

Overview:
- Round-robin arbiter that shares the single router datapath (FSM, register, FIFOs) between N_PORTS packet sources.
- Grants one source for a whole packet, from header through parity, and muxes its byte stream onto the shared pkt_valid/data_in.
- Holds off the next grant until the router FSM deasserts busy, so packets never interleave.

Parameters:
- N_PORTS, 3, number of requesting source ports (2..4).
- DW, 8, byte width of the packet stream.
- DRAIN_TIMEOUT, 31, max cycles spent in S_DRAIN before watchdog release (used only with the optional feature).

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_PORTS  per-source pkt_valid; high for header+payload bytes, drops before the parity byte.
- src_data  in  N_PORTS*DW  per-source byte; port i occupies bits [i*DW +: DW].
- busy  in  1  router FSM busy.
- stall  in  1  router cannot accept a byte this cycle (fifo_full / full_state).
- abort  in  1  OR of soft_reset_0..2; kills the current grant.
- grant  out  N_PORTS  one-hot grant; source i may advance only when grant[i] & !stall.
- grant_idx  out  2  binary index of the granted port.
- grant_valid  out  1  a grant is held.
- pkt_valid_out  out  1  muxed pkt_valid to the router.
- data_out  out  DW  muxed byte to the router.
- timeout_err  out  1  one-cycle pulse on watchdog release (0 without feature).

Behaviour:
- Reset: state S_IDLE; grant=0; grant_idx=0; grant_valid=0; rr_ptr=N_PORTS-1, so port 0 wins first; timeout_err=0.
- Outputs grant, grant_idx, grant_valid and timeout_err are registered. data_out and pkt_valid_out are combinational muxes of the granted port, with zero added latency.
  - pkt_valid_out = grant_valid & req[grant_idx].
  - data_out = src_data[grant_idx] when grant_valid, else 0.
- S_IDLE: if |req and !busy and !abort:
  - pick the first requesting port searching rr_ptr+1, rr_ptr+2, ... modulo N_PORTS;
  - register the grant, go to S_XFER.
  - Grant is visible the cycle after the request.
  - If busy=1, stay in S_IDLE with no grant.
- S_XFER: grant held.
  - Going to S_DRAIN: in the cycle where req[grant_idx]=0 and stall=0, go to S_DRAIN. This is the parity-byte point.
  - If req drops while stall=1, remain in S_XFER until stall=0.
  - Other ports' req are ignored.
- S_DRAIN: grant still held, so the source can supply the parity byte.
  - When busy=0, go to S_IDLE: clear grant and set rr_ptr=grant_idx.
  - New arbitration happens earliest the cycle after.
- abort in any state:
  - next cycle state=S_IDLE and grant=0;
  - rr_ptr=grant_idx if a grant was held, so the aborted port loses priority.
  - abort has priority over all other transitions.
- Simultaneous requests are resolved strictly by rr_ptr order.
- A lone requester may be re-granted back-to-back, with at least one S_IDLE cycle between packets.
- Ports with index >= N_PORTS do not exist. grant_idx is zero-extended.
- reset mid-packet: identical to the reset values above on the next edge.

Optional Feature:
- Macro ROUTER_ARB_WATCHDOG_EN.
- When defined:
  - a 5-bit counter clears on entry to S_DRAIN and increments each cycle in S_DRAIN;
  - on reaching DRAIN_TIMEOUT while busy=1, force S_IDLE, clear the grant, advance rr_ptr, and pulse timeout_err for 1 cycle.
- When undefined:
  - S_DRAIN waits indefinitely;
  - timeout_err is tied to 0;
  - no counter is built.

Decomposition:
- Shared package router_pkg:
  - state encoding typedef arb_state_t (S_IDLE=2'b00, S_XFER=2'b01, S_DRAIN=2'b10);
  - constant MAX_PORTS=4.
- One sub-module, router_rr_pick: a combinational round-robin priority picker taking req and rr_ptr, producing a one-hot and an index. It is reusable for the output-side read arbiter.

Test Plan:
- Single source: after reset, req[1]=1.
  - Required: grant=3'b010, grant_idx=1 on the next edge.
  - data_out follows src_data[1] with zero latency.
  - req drops → S_DRAIN; busy low → grant=0 the following cycle.
- Contention: req=3'b111 held for three packets.
  - Required: grant order 0, 1, 2; then port 0 again.
  - Each grant is separated by ≥1 idle cycle after busy falls.
- Stall at end: req[0] drops in a cycle with stall=1.
  - Required: remains in S_XFER and grant held; enters S_DRAIN on the first stall=0 cycle.
- Busy blocking: busy=1 in S_IDLE with req=3'b001.
  - Required: no grant until busy=0; grant asserted the cycle after.
- Abort: abort pulse mid-S_XFER on port 2 while req=3'b101.
  - Required: grant=0 next cycle; the next grant goes to port 0.
- Watchdog (ROUTER_ARB_WATCHDOG_EN): busy stuck high in S_DRAIN.
  - Required: after 31 cycles, timeout_err pulses once, grant=0, and rr_ptr advances.
  - Without the macro: grant is held indefinitely.
